// File: rtl/lsu_trig_pkg.sv
// Shared types and store-data formatting for the LSU debug-trigger unit.
// Pure declarations: no latency, no backpressure.
package lsu_trig_pkg;

    typedef enum logic [1:0] {
        EXACT = 2'd0,
        NAPOT = 2'd1,
        GE    = 2'd2,
        LT    = 2'd3
    } lsu_trig_mode_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    typedef struct packed {
        logic           en;
        logic           sel;
        logic           ld;
        logic           st;
        lsu_trig_mode_e mode;
    } lsu_trig_cfg_t;

    function automatic logic [63:0] fmt_store(input logic [63:0] d, input lsu_size_e sz);
        case (sz)
            SIZE_B:  return {56'd0, d[7:0]};
            SIZE_H:  return {48'd0, d[15:0]};
            SIZE_W:  return {32'd0, d[31:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_trig_cmp.sv
// Operand select/format plus four-mode unsigned comparator for one trigger.
// Latency: combinational; no backpressure.
module lsu_trig_cmp
    import lsu_trig_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              sel,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] tdata2,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       store_data,
    input  logic [1:0]        size,
    output logic              match
);

    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] care;
    logic              ones;

    always_comb begin
        operand = '0;
        if (sel) begin
            operand[63:0] = fmt_store(store_data, lsu_size_e'(size));
        end else begin
            operand[ADDR_W-1:0] = addr;
        end

        // NAPOT: bit k is free once every tdata2 bit below it is one; bit 0 always compared.
        care = '1;
        ones = 1'b1;
        for (int k = 1; k < DATA_W; k++) begin
            ones    = ones & tdata2[k-1];
            care[k] = ~ones;
        end

        case (lsu_trig_mode_e'(mode))
            EXACT:   match = (operand == tdata2);
            NAPOT:   match = (((operand ^ tdata2) & care) == '0);
            GE:      match = (operand >= tdata2);
            default: match = (operand < tdata2);
        endcase
    end

endmodule

// File: rtl/lsu_trigger_ctl.sv
// N-trigger LSU debug matcher with pairwise chaining, hit thresholds and sticky status.
// Latency: fire registered one cycle after the DC3 access; no stalls or backpressure.
module lsu_trigger_ctl
    import lsu_trig_pkg::*;
#(
    parameter int NUM_TRIG = 4,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_TRIG-1:0]          trig_en,
    input  logic [NUM_TRIG-1:0]          trig_select,
    input  logic [NUM_TRIG-1:0]          trig_load,
    input  logic [NUM_TRIG-1:0]          trig_store,
    input  logic [2*NUM_TRIG-1:0]        trig_mode,
    input  logic [NUM_TRIG-1:0]          trig_chain,
    input  logic [NUM_TRIG*CNT_W-1:0]    trig_count,
    input  logic [NUM_TRIG*DATA_W-1:0]   trig_tdata2,
    input  logic [NUM_TRIG-1:0]          trig_cfg_wr,
    input  logic                         lsu_valid_dc3,
    input  logic                         lsu_dma_dc3,
    input  logic                         lsu_load_dc3,
    input  logic                         lsu_store_dc3,
    input  logic                         lsu_flush_dc3,
    input  logic [1:0]                   lsu_size_dc3,
    input  logic [ADDR_W-1:0]            lsu_addr_dc3,
    input  logic [DATA_W-1:0]            store_data_dc3,
    input  logic [NUM_TRIG-1:0]          hit_clr,
    output logic [NUM_TRIG-1:0]          lsu_trigger_match_dc4,
    output logic [NUM_TRIG-1:0]          trigger_hit_sticky
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                acc;
    logic [NUM_TRIG-1:0] raw;
    logic [NUM_TRIG-1:0] evt;

    assign acc = lsu_valid_dc3 & ~lsu_dma_dc3 & ~lsu_flush_dc3;

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
        lsu_trig_cfg_t    cfg;
        logic             cmp_hit;
        logic [CNT_W-1:0] thr;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             match_q, match_d;
        logic             sticky_q, sticky_d;

        assign cfg = '{en:   trig_en[i],
                       sel:  trig_select[i],
                       ld:   trig_load[i],
                       st:   trig_store[i],
                       mode: lsu_trig_mode_e'(trig_mode[2*i +: 2])};
        assign thr = trig_count[i*CNT_W +: CNT_W];

        lsu_trig_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cmp (
            .sel        (cfg.sel),
            .mode       (cfg.mode),
            .tdata2     (trig_tdata2[i*DATA_W +: DATA_W]),
            .addr       (lsu_addr_dc3),
            .store_data (store_data_dc3[63:0]),
            .size       (lsu_size_dc3),
            .match      (cmp_hit)
        );

        assign raw[i] = acc & cfg.en & cmp_hit &
                        ((cfg.st & lsu_store_dc3) | (cfg.ld & lsu_load_dc3 & ~cfg.sel));

        always_comb begin
            cnt_d   = cnt_q;
            match_d = 1'b0;
            if (trig_cfg_wr[i]) begin
                cnt_d = '0;
            end else if (evt[i]) begin
                if (thr <= CNT_ONE) begin
                    match_d = 1'b1;
                end else if (cnt_q + CNT_ONE == thr) begin
                    match_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            sticky_d = match_d | (sticky_q & ~hit_clr[i]);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q    <= '0;
                match_q  <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                match_q  <= match_d;
                sticky_q <= sticky_d;
            end
        end

        assign lsu_trigger_match_dc4[i] = match_q;
        assign trigger_hit_sticky[i]    = sticky_q;
    end

    for (genvar p = 0; p < NUM_TRIG / 2; p++) begin : g_pair
        localparam int E = 2 * p;
        localparam int O = 2 * p + 1;

        logic armed_q, armed_d;
        logic evt_e, evt_o;

        always_comb begin
            evt_e   = raw[E] & ~trig_chain[E] & ~trig_cfg_wr[E];
            evt_o   = raw[O] & (~trig_chain[E] | armed_q) & ~trig_cfg_wr[O];
            armed_d = armed_q;
            // Head hit re-arms even when the tail fires in the same cycle.
            if (trig_chain[E]) begin
                if (raw[E]) begin
                    armed_d = 1'b1;
                end else if (evt_o) begin
                    armed_d = 1'b0;
                end
            end
            if (trig_cfg_wr[O] | (trig_cfg_wr[E] & trig_chain[E])) begin
                armed_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                armed_q <= 1'b0;
            end else begin
                armed_q <= armed_d;
            end
        end

        assign evt[E] = evt_e;
        assign evt[O] = evt_o;
    end

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// Directed self-checking bench for lsu_trigger_ctl.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_lsu_trigger_ctl;
    import lsu_trig_pkg::*;

    localparam int NUM_TRIG = 4;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_TRIG-1:0]        trig_en, trig_select, trig_load, trig_store;
    logic [2*NUM_TRIG-1:0]      trig_mode;
    logic [NUM_TRIG-1:0]        trig_chain, trig_cfg_wr, hit_clr;
    logic [NUM_TRIG*CNT_W-1:0]  trig_count;
    logic [NUM_TRIG*DATA_W-1:0] trig_tdata2;
    logic                       lsu_valid_dc3, lsu_dma_dc3, lsu_load_dc3, lsu_store_dc3, lsu_flush_dc3;
    logic [1:0]                 lsu_size_dc3;
    logic [ADDR_W-1:0]          lsu_addr_dc3;
    logic [DATA_W-1:0]          store_data_dc3;
    logic [NUM_TRIG-1:0]        lsu_trigger_match_dc4, trigger_hit_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_trigger_ctl #(.NUM_TRIG(NUM_TRIG), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .trig_en               (trig_en),
        .trig_select           (trig_select),
        .trig_load             (trig_load),
        .trig_store            (trig_store),
        .trig_mode             (trig_mode),
        .trig_chain            (trig_chain),
        .trig_count            (trig_count),
        .trig_tdata2           (trig_tdata2),
        .trig_cfg_wr           (trig_cfg_wr),
        .lsu_valid_dc3         (lsu_valid_dc3),
        .lsu_dma_dc3           (lsu_dma_dc3),
        .lsu_load_dc3          (lsu_load_dc3),
        .lsu_store_dc3         (lsu_store_dc3),
        .lsu_flush_dc3         (lsu_flush_dc3),
        .lsu_size_dc3          (lsu_size_dc3),
        .lsu_addr_dc3          (lsu_addr_dc3),
        .store_data_dc3        (store_data_dc3),
        .hit_clr               (hit_clr),
        .lsu_trigger_match_dc4 (lsu_trigger_match_dc4),
        .trigger_hit_sticky    (trigger_hit_sticky)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int i, input logic en, input logic sel, input logic ld, input logic st,
                       input logic [1:0] mode, input logic [CNT_W-1:0] cnt, input logic [DATA_W-1:0] t2);
        trig_en[i]                       = en;
        trig_select[i]                   = sel;
        trig_load[i]                     = ld;
        trig_store[i]                    = st;
        trig_mode[2*i +: 2]              = mode;
        trig_count[i*CNT_W +: CNT_W]     = cnt;
        trig_tdata2[i*DATA_W +: DATA_W]  = t2;
    endtask

    task automatic acc(input logic ld, input logic st, input logic [1:0] sz,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        lsu_valid_dc3  = 1'b1;
        lsu_dma_dc3    = 1'b0;
        lsu_flush_dc3  = 1'b0;
        lsu_load_dc3   = ld;
        lsu_store_dc3  = st;
        lsu_size_dc3   = sz;
        lsu_addr_dc3   = a;
        store_data_dc3 = d;
    endtask

    task automatic idle;
        lsu_valid_dc3 = 1'b0;
        lsu_load_dc3  = 1'b0;
        lsu_store_dc3 = 1'b0;
    endtask

    task automatic ld_step(input logic [ADDR_W-1:0] a, input logic [3:0] exp, input string tag);
        acc(1'b1, 1'b0, 2'd2, a, '0);
        tick;
        chk(tag, lsu_trigger_match_dc4, exp);
    endtask

    initial begin
        rst = 1'b1;
        trig_en = '0; trig_select = '0; trig_load = '0; trig_store = '0;
        trig_mode = '0; trig_chain = '0; trig_count = '0; trig_tdata2 = '0;
        trig_cfg_wr = '0; hit_clr = '0;
        lsu_dma_dc3 = 1'b0; lsu_flush_dc3 = 1'b0; lsu_size_dc3 = 2'd0;
        lsu_addr_dc3 = '0; store_data_dc3 = '0;
        idle;

        // Reset dominates a hitting access.
        cfg(0, 1'b1, 1'b0, 1'b1, 1'b0, NAPOT, 8'd0, 64'h1000_00FF);
        acc(1'b1, 1'b0, 2'd2, 32'h1000_01C3, '0);
        tick;
        tick;
        chk("reset_match", lsu_trigger_match_dc4, 4'b0000);
        chk("reset_sticky", trigger_hit_sticky, 4'b0000);
        rst = 1'b0;

        // NAPOT: bits 8:1 free, bit 0 and bit 9+ compared.
        ld_step(32'h1000_01C3, 4'b0001, "napot_hit");
        chk("napot_sticky", trigger_hit_sticky, 4'b0001);
        ld_step(32'h1000_0243, 4'b0000, "napot_bit9");
        ld_step(32'h1000_0042, 4'b0000, "napot_bit0");

        cfg(0, 1'b1, 1'b0, 1'b1, 1'b0, EXACT, 8'd0, 64'h1000_0042);
        ld_step(32'h1000_0042, 4'b0001, "exact_hit");
        ld_step(32'h1000_0043, 4'b0000, "exact_miss");
        chk("sticky_hold", trigger_hit_sticky, 4'b0001);
        trig_en[0] = 1'b0;

        // Store-data compare with size formatting.
        cfg(1, 1'b1, 1'b1, 1'b1, 1'b1, EXACT, 8'd0, 64'h0000_0000_0000_00A5);
        acc(1'b0, 1'b1, 2'd0, 32'h0, 64'hFFFF_FFA5);
        tick;
        chk("st_byte", lsu_trigger_match_dc4, 4'b0010);
        acc(1'b0, 1'b1, 2'd2, 32'h0, 64'hFFFF_FFA5);
        tick;
        chk("st_word", lsu_trigger_match_dc4, 4'b0000);
        acc(1'b1, 1'b0, 2'd0, 32'hA5, 64'hFFFF_FFA5);
        tick;
        chk("sel_load", lsu_trigger_match_dc4, 4'b0000);
        trig_en[1] = 1'b0;

        // Range modes.
        cfg(2, 1'b1, 1'b0, 1'b1, 1'b0, GE, 8'd0, 64'h2000);
        cfg(3, 1'b1, 1'b0, 1'b1, 1'b0, LT, 8'd0, 64'h3000);
        ld_step(32'h2800, 4'b1100, "range_mid");
        ld_step(32'h3000, 4'b0100, "range_top");
        ld_step(32'h1FFF, 4'b1000, "range_low");
        chk("sticky_all", trigger_hit_sticky, 4'b1111);

        // Clear versus simultaneous fire.
        hit_clr = 4'b1111;
        ld_step(32'h3000, 4'b0100, "clr_fire");
        chk("clr_set_wins", trigger_hit_sticky, 4'b0100);
        hit_clr = 4'b0000;
        idle;
        tick;
        chk("clr_hold", trigger_hit_sticky, 4'b0100);
        chk("pulse_drop", lsu_trigger_match_dc4, 4'b0000);

        // Chain T0 -> T1.
        trig_en = '0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        cfg(0, 1'b1, 1'b0, 1'b1, 1'b0, EXACT, 8'd0, 64'h100);
        cfg(1, 1'b1, 1'b0, 1'b1, 1'b0, EXACT, 8'd0, 64'h200);
        trig_chain = 4'b0001;
        ld_step(32'h200, 4'b0000, "chain_t1_only");
        ld_step(32'h100, 4'b0000, "chain_arm");
        idle;
        tick;
        chk("chain_gap", lsu_trigger_match_dc4, 4'b0000);
        ld_step(32'h200, 4'b0010, "chain_fire");
        ld_step(32'h200, 4'b0000, "chain_disarmed");

        cfg(1, 1'b1, 1'b0, 1'b1, 1'b0, GE, 8'd0, 64'h100);
        ld_step(32'h100, 4'b0000, "chain_both_unarmed");
        ld_step(32'h180, 4'b0010, "chain_after_both");
        ld_step(32'h100, 4'b0000, "chain_rearm");
        ld_step(32'h100, 4'b0010, "chain_hold_armed");
        ld_step(32'h180, 4'b0010, "chain_still_armed");
        ld_step(32'h180, 4'b0000, "chain_cleared");

        ld_step(32'h100, 4'b0000, "arm_again");
        trig_cfg_wr = 4'b0001;
        idle;
        tick;
        trig_cfg_wr = 4'b0000;
        ld_step(32'h180, 4'b0000, "cfgwr_disarm");

        ld_step(32'h100, 4'b0000, "arm_rst");
        rst = 1'b1;
        idle;
        tick;
        chk("rst_match", lsu_trigger_match_dc4, 4'b0000);
        chk("rst_sticky", trigger_hit_sticky, 4'b0000);
        rst = 1'b0;
        ld_step(32'h180, 4'b0000, "rst_disarm");

        // Hit-count threshold of 3.
        trig_en = '0;
        trig_chain = '0;
        cfg(2, 1'b1, 1'b0, 1'b1, 1'b0, EXACT, 8'd3, 64'h40);
        for (int i = 0; i < 5; i++) begin
            ld_step(32'h40, (i == 2) ? 4'b0100 : 4'b0000, "cnt5");
        end
        trig_cfg_wr = 4'b0100;
        idle;
        tick;
        trig_cfg_wr = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            ld_step(32'h40, (i == 2) ? 4'b0100 : 4'b0000, "cnt_after_wr");
        end

        // Flushed and DMA accesses neither fire nor count.
        acc(1'b1, 1'b0, 2'd2, 32'h40, '0);
        lsu_flush_dc3 = 1'b1;
        tick;
        chk("flush", lsu_trigger_match_dc4, 4'b0000);
        acc(1'b1, 1'b0, 2'd2, 32'h40, '0);
        lsu_dma_dc3 = 1'b1;
        tick;
        chk("dma", lsu_trigger_match_dc4, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            ld_step(32'h40, (i == 2) ? 4'b0100 : 4'b0000, "cnt_after_flush");
        end

        idle;
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
